// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the SRAM BIST engine.
package sram_bist_pkg;

  localparam int SRAM_DEPTH = 64000;

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_ADDR  = 2'd1;
  localparam logic [1:0] MODE_ALT   = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_FIN
  } state_t;

endpackage

// File: rtl/sram_bist_pattern.sv
// Pattern generator: data word for index idx of a run.
module sram_bist_pattern
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] idx,
  output logic [DATA_W-1:0] data
);

  logic [ADDR_W-1:0] addr;
  assign addr = base + idx;

  // Select pattern by mode; reserved mode never reaches here (rejected at start).
  always_comb begin
    data = seed;
    case (mode)
      MODE_ADDR: data = seed ^ DATA_W'(addr);
      MODE_ALT:  data = idx[0] ? ~seed : seed;
      default:   data = seed;
    endcase
  end

endmodule

// File: rtl/sram_bist_engine.sv
// Avalon-MM BIST master: fill an SRAM window with a pattern, read it back,
// count mismatches and record the first failing word.
module sram_bist_engine
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = SRAM_DEPTH,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W:0]     cfg_len,
  input  logic [1:0]          cfg_mode,
  input  logic [DATA_W-1:0]   cfg_seed,
  input  logic                cfg_wr_only,
  output logic [ADDR_W-1:0]   sram_address,
  output logic [DATA_W/8-1:0] sram_byteenable,
  output logic                sram_chipselect,
  output logic                sram_write,
  output logic [DATA_W-1:0]   sram_writedata,
  output logic                sram_clken,
  input  logic [DATA_W-1:0]   sram_readdata,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                cfg_err,
  output logic                aborted,
  output logic [CNT_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   fail_addr,
  output logic [DATA_W-1:0]   fail_data
);

  // Read pipeline entry: address issued last cycle and the word expected back.
  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp;
  } rd_ent_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] seed_q;
  logic              wr_only_q;
  logic [ADDR_W:0]   idx_q;
  rd_ent_t           rd_q;

  logic              cfg_bad, last;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] wr_pat, rd_pat;
  logic              mism;
  logic [CNT_W-1:0]  err_nxt;

  // base+len is evaluated two bits wider so overflow past DEPTH is caught.
  assign cfg_bad    = (({2'b00, cfg_base} + {1'b0, cfg_len}) > (ADDR_W+2)'(DEPTH)) ||
                      (cfg_mode == MODE_RSVD);
  assign last       = (idx_q == len_q - (ADDR_W+1)'(1));
  assign issue_addr = base_q + idx_q[ADDR_W-1:0];

  sram_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_pat (
    .mode(mode_q), .seed(seed_q), .base(base_q), .idx(idx_q[ADDR_W-1:0]), .data(wr_pat)
  );

  sram_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_pat (
    .mode(mode_q), .seed(seed_q), .base(base_q), .idx(idx_q[ADDR_W-1:0]), .data(rd_pat)
  );

  // Compare the word returned for last cycle's address; an abort discards it.
  assign mism    = rd_q.vld && !abort && (state == S_READ || state == S_DRAIN) &&
                   (sram_readdata != rd_q.exp);
  assign err_nxt = (mism && (err_count != '1)) ? err_count + CNT_W'(1) : err_count;

  // Bus and status decode straight from state so abort drops the bus next cycle.
  always_comb begin
    busy            = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
    done            = (state == S_FIN);
    sram_chipselect = (state == S_WRITE) || (state == S_READ);
    sram_write      = (state == S_WRITE);
    sram_address    = sram_chipselect ? issue_addr : '0;
    sram_writedata  = sram_write ? wr_pat : '0;
    sram_clken      = 1'b1;
    sram_byteenable = '1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (cfg_bad || cfg_len == '0) ? S_FIN : S_WRITE;
      S_WRITE: if (abort) state_nxt = S_FIN;
               else if (last) state_nxt = wr_only_q ? S_FIN : S_READ;
      S_READ:  if (abort) state_nxt = S_FIN;
               else if (last) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Config latch, word index, read pipeline and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q    <= '0;
      len_q     <= '0;
      mode_q    <= MODE_CONST;
      seed_q    <= '0;
      wr_only_q <= 1'b0;
      idx_q     <= '0;
      rd_q      <= '0;
      pass      <= 1'b0;
      cfg_err   <= 1'b0;
      aborted   <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      rd_q.vld <= 1'b0;
      if (state == S_READ || state == S_DRAIN) begin
        err_count <= err_nxt;
        if (mism && err_count == '0) begin
          fail_addr <= rd_q.addr;
          fail_data <= sram_readdata;
        end
      end
      case (state)
        S_IDLE: if (start) begin
          base_q    <= cfg_base;
          len_q     <= cfg_len;
          mode_q    <= cfg_mode;
          seed_q    <= cfg_seed;
          wr_only_q <= cfg_wr_only;
          idx_q     <= '0;
          cfg_err   <= cfg_bad;
          pass      <= !cfg_bad && (cfg_len == '0);
          aborted   <= 1'b0;
          err_count <= '0;
          fail_addr <= '0;
          fail_data <= '0;
        end
        S_WRITE: begin
          if (abort) aborted <= 1'b1;
          else if (last) begin
            idx_q <= '0;
            if (wr_only_q) pass <= 1'b1;
          end else idx_q <= idx_q + (ADDR_W+1)'(1);
        end
        S_READ: begin
          rd_q.vld  <= !abort;
          rd_q.addr <= issue_addr;
          rd_q.exp  <= rd_pat;
          if (abort) aborted <= 1'b1;
          else if (!last) idx_q <= idx_q + (ADDR_W+1)'(1);
        end
        S_DRAIN: begin
          if (abort) aborted <= 1'b1;
          else pass <= (err_nxt == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bist_engine.sv
// Bench for sram_bist_engine: SRAM model with optional read corruption and a
// spec-level reference model of each run's bus traffic and result.
module tb_sram_bist_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [15:0] cfg_base = '0;
  logic [16:0] cfg_len = '0;
  logic [1:0]  cfg_mode = '0;
  logic [31:0] cfg_seed = '0;
  logic        cfg_wr_only = 1'b0;
  logic [15:0] sram_address;
  logic [3:0]  sram_byteenable;
  logic        sram_chipselect, sram_write, sram_clken;
  logic [31:0] sram_writedata, sram_readdata;
  logic        busy, done, pass, cfg_err, aborted;
  logic [15:0] err_count, fail_addr;
  logic [31:0] fail_data;

  int errs = 0, checks = 0;

  sram_bist_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_mode(cfg_mode),
    .cfg_seed(cfg_seed), .cfg_wr_only(cfg_wr_only),
    .sram_address(sram_address), .sram_byteenable(sram_byteenable),
    .sram_chipselect(sram_chipselect), .sram_write(sram_write),
    .sram_writedata(sram_writedata), .sram_clken(sram_clken),
    .sram_readdata(sram_readdata), .busy(busy), .done(done), .pass(pass),
    .cfg_err(cfg_err), .aborted(aborted), .err_count(err_count),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  // SRAM model: registered address, unregistered q, optional corrupted word.
  logic [31:0] mem [0:65535];
  logic [15:0] addr_q = '0;
  logic        corrupt_en = 1'b0;
  logic [15:0] corrupt_addr = '0;
  logic [31:0] corrupt_val = '0;
  always @(posedge clk) begin
    if (sram_chipselect && sram_clken) begin
      if (sram_write) mem[sram_address] <= sram_writedata;
      addr_q <= sram_address;
    end
  end
  assign sram_readdata = (corrupt_en && addr_q == corrupt_addr) ? corrupt_val : mem[addr_q];

  // Observations of one run.
  typedef struct packed { logic [15:0] a; logic [31:0] d; } wr_t;
  wr_t         wq[$];
  int          rd_n, cyc_done;
  logic        o_pass, o_cfg_err, o_aborted, o_busy;
  logic [15:0] o_err, o_faddr;
  logic [31:0] o_fdata;

  function automatic logic [31:0] pat(input logic [1:0] m, input logic [31:0] s,
                                      input logic [15:0] b, input int i);
    logic [15:0] a;
    a = b + 16'(i);
    case (m)
      2'd1:    return s ^ {16'h0, a};
      2'd2:    return (i % 2 == 1) ? ~s : s;
      default: return s;
    endcase
  endfunction

  // Drive one run and record bus traffic until done (bounded). ab_cyc: cycle
  // (relative to start, 0 = together with start) in which abort is pulsed.
  task automatic run(input logic [15:0] b, input logic [16:0] l, input logic [1:0] m,
                     input logic [31:0] s, input logic wo, input int ab_cyc);
    int budget;
    budget = 4 * int'(l) + 20;
    if (budget > 400) budget = 400;
    wq.delete(); rd_n = 0; cyc_done = -1;
    @(negedge clk);
    cfg_base = b; cfg_len = l; cfg_mode = m; cfg_seed = s; cfg_wr_only = wo;
    start = 1'b1; abort = (ab_cyc == 0);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = 1'b0; abort = (ab_cyc == c);
      if (sram_chipselect) begin
        if (sram_write) wq.push_back('{a: sram_address, d: sram_writedata});
        else rd_n++;
      end
      if (done) begin
        cyc_done = c; o_pass = pass; o_cfg_err = cfg_err; o_aborted = aborted;
        o_busy = busy; o_err = err_count; o_faddr = fail_addr; o_fdata = fail_data;
        break;
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    checks++; if (sram_chipselect !== 1'b0 || sram_write !== 1'b0) begin errs++; $display("FAIL reset_cs_wr got %b%b want 00", sram_chipselect, sram_write); end
    checks++; if (sram_clken !== 1'b1 || sram_byteenable !== 4'hF) begin errs++; $display("FAIL reset_clken_be got %b %h want 1 f", sram_clken, sram_byteenable); end
    checks++; if (pass !== 1'b0 || cfg_err !== 1'b0 || aborted !== 1'b0) begin errs++; $display("FAIL reset_flags got %b%b%b want 000", pass, cfg_err, aborted); end
    checks++; if (err_count !== '0 || fail_addr !== '0 || fail_data !== '0 || sram_address !== '0) begin errs++; $display("FAIL reset_values got %h %h %h %h want 0", err_count, fail_addr, fail_data, sram_address); end
  endtask

  task automatic test_basic;
    run(16'd0, 17'd4, 2'd0, 32'hA5A5A5A5, 1'b0, -1);
    checks++; if (cyc_done !== 10) begin errs++; $display("FAIL basic_latency got %0d want 10", cyc_done); end
    checks++; if (wq.size() !== 4 || rd_n !== 4) begin errs++; $display("FAIL basic_traffic got wr=%0d rd=%0d want 4 4", wq.size(), rd_n); end
    for (int i = 0; i < wq.size() && i < 4; i++) begin
      checks++; if (wq[i].a !== 16'(i) || wq[i].d !== 32'hA5A5A5A5) begin errs++; $display("FAIL basic_write%0d got %h/%h want %h/a5a5a5a5", i, wq[i].a, wq[i].d, 16'(i)); end
    end
    checks++; if (o_pass !== 1'b1 || o_err !== 16'd0 || o_busy !== 1'b0) begin errs++; $display("FAIL basic_result got pass=%b err=%0d busy=%b want 1 0 0", o_pass, o_err, o_busy); end
  endtask

  task automatic test_corrupt;
    corrupt_en = 1'b1; corrupt_addr = 16'd101; corrupt_val = 32'h0000DEAD;
    run(16'd100, 17'd3, 2'd1, 32'h0, 1'b0, -1);
    corrupt_en = 1'b0;
    checks++; if (o_err !== 16'd1 || o_pass !== 1'b0) begin errs++; $display("FAIL corrupt_count got err=%0d pass=%b want 1 0", o_err, o_pass); end
    checks++; if (o_faddr !== 16'd101 || o_fdata !== 32'hDEAD) begin errs++; $display("FAIL corrupt_first got %0d/%h want 101/0000dead", o_faddr, o_fdata); end
    checks++; if (wq.size() !== 3 || (wq.size() == 3 && wq[2].d !== 32'd102)) begin errs++; $display("FAIL corrupt_writes got n=%0d want 3 with addr pattern", wq.size()); end
  endtask

  task automatic test_cfg;
    run(16'd63990, 17'd11, 2'd0, 32'h1, 1'b0, -1);
    checks++; if (o_cfg_err !== 1'b1 || o_pass !== 1'b0) begin errs++; $display("FAIL range_err got cfg_err=%b pass=%b want 1 0", o_cfg_err, o_pass); end
    checks++; if (cyc_done !== 1 || wq.size() + rd_n !== 0) begin errs++; $display("FAIL range_timing got done@%0d acc=%0d want 1 0", cyc_done, wq.size() + rd_n); end
    run(16'd63990, 17'd10, 2'd0, 32'h1, 1'b1, -1);
    checks++; if (o_cfg_err !== 1'b0 || o_pass !== 1'b1 || wq.size() !== 10) begin errs++; $display("FAIL range_edge got cfg_err=%b pass=%b wr=%0d want 0 1 10", o_cfg_err, o_pass, wq.size()); end
    run(16'd5, 17'd0, 2'd0, 32'h1, 1'b0, -1);
    checks++; if (o_pass !== 1'b1 || o_cfg_err !== 1'b0 || cyc_done !== 1 || wq.size() + rd_n !== 0) begin errs++; $display("FAIL len0 got pass=%b cfg_err=%b done@%0d acc=%0d want 1 0 1 0", o_pass, o_cfg_err, cyc_done, wq.size() + rd_n); end
    run(16'd5, 17'd4, 2'd3, 32'h1, 1'b0, -1);
    checks++; if (o_cfg_err !== 1'b1 || wq.size() + rd_n !== 0) begin errs++; $display("FAIL mode3 got cfg_err=%b acc=%0d want 1 0", o_cfg_err, wq.size() + rd_n); end
  endtask

  task automatic test_abort;
    // len 8: writes in cycles 1..8, reads start at cycle 9; abort during cycle 10.
    run(16'd300, 17'd8, 2'd0, 32'h12345678, 1'b0, 10);
    checks++; if (cyc_done !== 11 || rd_n !== 2) begin errs++; $display("FAIL abort_stop got done@%0d rd=%0d want 11 2", cyc_done, rd_n); end
    checks++; if (o_aborted !== 1'b1 || o_pass !== 1'b0 || o_err !== 16'd0) begin errs++; $display("FAIL abort_flags got ab=%b pass=%b err=%0d want 1 0 0", o_aborted, o_pass, o_err); end
    run(16'd300, 17'd3, 2'd0, 32'h1, 1'b0, 0);
    checks++; if (o_aborted !== 1'b0 || o_pass !== 1'b1 || cyc_done !== 8) begin errs++; $display("FAIL start_abort_idle got ab=%b pass=%b done@%0d want 0 1 8", o_aborted, o_pass, cyc_done); end
  endtask

  task automatic test_alt_wr_only;
    logic [31:0] exp [4];
    exp[0] = 32'h0000FFFF; exp[1] = 32'hFFFF0000; exp[2] = 32'h0000FFFF; exp[3] = 32'hFFFF0000;
    run(16'd40, 17'd4, 2'd2, 32'h0000FFFF, 1'b1, -1);
    checks++; if (wq.size() !== 4 || rd_n !== 0 || o_pass !== 1'b1 || cyc_done !== 5) begin errs++; $display("FAIL alt_summary got wr=%0d rd=%0d pass=%b done@%0d want 4 0 1 5", wq.size(), rd_n, o_pass, cyc_done); end
    for (int i = 0; i < wq.size() && i < 4; i++) begin
      checks++; if (wq[i].d !== exp[i]) begin errs++; $display("FAIL alt_data%0d got %h want %h", i, wq[i].d, exp[i]); end
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 8; t++) begin
      logic [15:0] b; logic [16:0] l; logic [1:0] m; logic [31:0] s; logic wo;
      int e_err, e_cyc, e_rd; logic [15:0] e_fa; logic [31:0] e_fd; logic [31:0] rv; int bad_w;
      b = 16'($urandom_range(0, 2000)); l = 17'($urandom_range(1, 24));
      m = 2'($urandom_range(0, 2)); s = $urandom; wo = 1'($urandom_range(0, 1));
      corrupt_en = 1'($urandom_range(0, 1));
      corrupt_addr = b + 16'($urandom_range(0, 30)); corrupt_val = $urandom;
      e_err = 0; e_fa = '0; e_fd = '0;
      e_rd = wo ? 0 : int'(l);
      e_cyc = wo ? int'(l) + 1 : 2 * int'(l) + 2;
      for (int i = 0; i < e_rd; i++) begin
        rv = (corrupt_en && corrupt_addr == b + 16'(i)) ? corrupt_val : pat(m, s, b, i);
        if (rv != pat(m, s, b, i)) begin
          if (e_err == 0) begin e_fa = b + 16'(i); e_fd = rv; end
          e_err++;
        end
      end
      run(b, l, m, s, wo, -1);
      corrupt_en = 1'b0;
      bad_w = (wq.size() == int'(l)) ? 0 : 1;
      for (int i = 0; i < wq.size(); i++)
        if (wq[i].a !== b + 16'(i) || wq[i].d !== pat(m, s, b, i)) bad_w++;
      checks++; if (bad_w != 0) begin errs++; $display("FAIL rand%0d_writes got %0d bad of %0d want 0 bad of %0d", t, bad_w, wq.size(), l); end
      checks++; if (cyc_done !== e_cyc || rd_n !== e_rd) begin errs++; $display("FAIL rand%0d_timing got done@%0d rd=%0d want %0d %0d", t, cyc_done, rd_n, e_cyc, e_rd); end
      checks++; if (o_err !== 16'(e_err) || o_pass !== (e_err == 0)) begin errs++; $display("FAIL rand%0d_result got err=%0d pass=%b want %0d %b", t, o_err, o_pass, e_err, e_err == 0); end
      if (e_err != 0) begin
        checks++; if (o_faddr !== e_fa || o_fdata !== e_fd) begin errs++; $display("FAIL rand%0d_first got %h/%h want %h/%h", t, o_faddr, o_fdata, e_fa, e_fd); end
      end
    end
  endtask

  task automatic test_reset_midrun;
    @(negedge clk);
    cfg_base = 16'd500; cfg_len = 17'd20; cfg_mode = 2'd0; cfg_wr_only = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sram_chipselect !== 1'b1) begin errs++; $display("FAIL midrun_active got cs=%b want 1", sram_chipselect); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (sram_chipselect !== 1'b0 || sram_write !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL midrun_reset got cs=%b wr=%b busy=%b want 000", sram_chipselect, sram_write, busy); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    reset_n = 1'b1;
    test_basic;
    test_corrupt;
    test_cfg;
    test_abort;
    test_alt_wr_only;
    test_random;
    test_reset_midrun;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
